// File: rtl/hazard_ctrl.sv
// Hazard controller: tracks in-flight writers in E/M/W, decides F/D stall and
// produces forwarding selects for the D, E and M stage operands.
module hazard_ctrl #(
   parameter int ADDR_W = 5,
   parameter int T_W    = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] d_raddr0,
   input  logic [ADDR_W-1:0] d_raddr1,
   input  logic [T_W-1:0]    d_tuse0,
   input  logic [T_W-1:0]    d_tuse1,
   input  logic [ADDR_W-1:0] d_waddr,
   input  logic [T_W-1:0]    d_tnew,
   output logic              stall,
   output logic [1:0]        fwd_d0,
   output logic [1:0]        fwd_d1,
   output logic [1:0]        fwd_e0,
   output logic [1:0]        fwd_e1,
   output logic              fwd_m1
);

   logic [ADDR_W-1:0] r_e_raddr0;
   logic [ADDR_W-1:0] r_e_raddr1;
   logic [ADDR_W-1:0] r_e_waddr;
   logic [T_W-1:0]    r_e_tnew;
   logic [ADDR_W-1:0] r_m_raddr1;
   logic [ADDR_W-1:0] r_m_waddr;
   logic [T_W-1:0]    r_m_tnew;
   logic [ADDR_W-1:0] r_w_waddr;

   logic              w_stall;
   logic [T_W-1:0]    w_e_tnew_dec;

   // Register 0 is hardwired; it never produces a dependency.
   function automatic logic f_match(input logic [ADDR_W-1:0] waddr,
                                    input logic [ADDR_W-1:0] a);
      return (a != '0) && (waddr == a);
   endfunction

   function automatic logic f_hazard(input logic [ADDR_W-1:0] a,
                                     input logic [T_W-1:0]    tuse,
                                     input logic [ADDR_W-1:0] e_waddr,
                                     input logic [T_W-1:0]    e_tnew,
                                     input logic [ADDR_W-1:0] m_waddr,
                                     input logic [T_W-1:0]    m_tnew);
      return (f_match(e_waddr, a) && (e_tnew > tuse)) ||
             (f_match(m_waddr, a) && (m_tnew > tuse));
   endfunction

   // A producer that is still computing falls through to the next older stage.
   function automatic logic [1:0] f_fwd_d(input logic [ADDR_W-1:0] a,
                                          input logic [ADDR_W-1:0] e_waddr,
                                          input logic [T_W-1:0]    e_tnew,
                                          input logic [ADDR_W-1:0] m_waddr,
                                          input logic [T_W-1:0]    m_tnew,
                                          input logic [ADDR_W-1:0] w_waddr);
      logic [1:0] sel;
      sel = 2'd0;
      if (f_match(e_waddr, a) && (e_tnew == '0)) begin
         sel = 2'd1;
      end else if (f_match(m_waddr, a) && (m_tnew == '0)) begin
         sel = 2'd2;
      end else if (f_match(w_waddr, a)) begin
         sel = 2'd3;
      end
      return sel;
   endfunction

   function automatic logic [1:0] f_fwd_e(input logic [ADDR_W-1:0] a,
                                          input logic [ADDR_W-1:0] m_waddr,
                                          input logic [T_W-1:0]    m_tnew,
                                          input logic [ADDR_W-1:0] w_waddr);
      logic [1:0] sel;
      sel = 2'd0;
      if (f_match(m_waddr, a) && (m_tnew == '0)) begin
         sel = 2'd1;
      end else if (f_match(w_waddr, a)) begin
         sel = 2'd2;
      end
      return sel;
   endfunction

   assign w_e_tnew_dec = (r_e_tnew == '0) ? '0 : (r_e_tnew - T_W'(1));

   always_comb begin
      w_stall = 1'b0;
      w_stall = f_hazard(d_raddr0, d_tuse0, r_e_waddr, r_e_tnew, r_m_waddr, r_m_tnew) ||
                f_hazard(d_raddr1, d_tuse1, r_e_waddr, r_e_tnew, r_m_waddr, r_m_tnew);
   end

   always_comb begin
      stall  = w_stall;
      fwd_d0 = f_fwd_d(d_raddr0, r_e_waddr, r_e_tnew, r_m_waddr, r_m_tnew, r_w_waddr);
      fwd_d1 = f_fwd_d(d_raddr1, r_e_waddr, r_e_tnew, r_m_waddr, r_m_tnew, r_w_waddr);
      fwd_e0 = f_fwd_e(r_e_raddr0, r_m_waddr, r_m_tnew, r_w_waddr);
      fwd_e1 = f_fwd_e(r_e_raddr1, r_m_waddr, r_m_tnew, r_w_waddr);
      fwd_m1 = f_match(r_w_waddr, r_m_raddr1);
   end

   // M and W always advance; a stall only replaces the E entry with a bubble.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_e_raddr0 <= '0;
         r_e_raddr1 <= '0;
         r_e_waddr  <= '0;
         r_e_tnew   <= '0;
         r_m_raddr1 <= '0;
         r_m_waddr  <= '0;
         r_m_tnew   <= '0;
         r_w_waddr  <= '0;
      end else begin
         if (w_stall) begin
            r_e_raddr0 <= '0;
            r_e_raddr1 <= '0;
            r_e_waddr  <= '0;
            r_e_tnew   <= '0;
         end else begin
            r_e_raddr0 <= d_raddr0;
            r_e_raddr1 <= d_raddr1;
            r_e_waddr  <= d_waddr;
            r_e_tnew   <= d_tnew;
         end
         r_m_raddr1 <= r_e_raddr1;
         r_m_waddr  <= r_e_waddr;
         r_m_tnew   <= w_e_tnew_dec;
         r_w_waddr  <= r_m_waddr;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed instruction sequences with
// hand-computed stall/forward expectations, checked by a negedge monitor.
module tb_hazard_ctrl;

   typedef logic [9:0] exp_t;

   logic       clk;
   logic       reset_n;
   logic [4:0] d_raddr0;
   logic [4:0] d_raddr1;
   logic [2:0] d_tuse0;
   logic [2:0] d_tuse1;
   logic [4:0] d_waddr;
   logic [2:0] d_tnew;
   logic       stall;
   logic [1:0] fwd_d0;
   logic [1:0] fwd_d1;
   logic [1:0] fwd_e0;
   logic [1:0] fwd_e1;
   logic       fwd_m1;
   exp_t       w_act;

   exp_t  q_exp[$];
   string q_name[$];
   int    n_cmp;
   int    n_err;

   localparam exp_t Z = '0;

   hazard_ctrl #(.ADDR_W(5), .T_W(3)) dut (
      .clk(clk), .reset_n(reset_n),
      .d_raddr0(d_raddr0), .d_raddr1(d_raddr1),
      .d_tuse0(d_tuse0), .d_tuse1(d_tuse1),
      .d_waddr(d_waddr), .d_tnew(d_tnew),
      .stall(stall), .fwd_d0(fwd_d0), .fwd_d1(fwd_d1),
      .fwd_e0(fwd_e0), .fwd_e1(fwd_e1), .fwd_m1(fwd_m1)
   );

   assign w_act = {stall, fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input logic s, input logic [1:0] d0, input logic [1:0] d1,
                               input logic [1:0] e0, input logic [1:0] e1, input logic m1);
      return {s, d0, d1, e0, e1, m1};
   endfunction

   task automatic compare(input string nm, input exp_t act, input exp_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got stall=%0b d0=%0d d1=%0d e0=%0d e1=%0d m1=%0b, expected stall=%0b d0=%0d d1=%0d e0=%0d e1=%0d m1=%0b",
                  nm, act[9], act[8:7], act[6:5], act[4:3], act[2:1], act[0],
                  exp[9], exp[8:7], exp[6:5], exp[4:3], exp[2:1], exp[0]);
      end
   endtask

   task automatic drive(input logic [4:0] r0, input logic [4:0] r1, input logic [2:0] u0,
                        input logic [2:0] u1, input logic [4:0] wa, input logic [2:0] tn);
      d_raddr0 = r0;
      d_raddr1 = r1;
      d_tuse0  = u0;
      d_tuse1  = u1;
      d_waddr  = wa;
      d_tnew   = tn;
   endtask

   // One D-stage instruction per cycle; expectation queued for the monitor.
   task automatic step(input string nm, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [2:0] u0, input logic [2:0] u1, input logic [4:0] wa,
                       input logic [2:0] tn, input exp_t exp);
      @(posedge clk);
      #1;
      drive(r0, r1, u0, u1, wa, tn);
      q_exp.push_back(exp);
      q_name.push_back(nm);
   endtask

   task automatic nop(input string nm, input exp_t exp);
      step(nm, 5'd0, 5'd0, 3'd7, 3'd7, 5'd0, 3'd0, exp);
   endtask

   task automatic lw1(input string nm);
      step(nm, 5'd2, 5'd0, 3'd1, 3'd7, 5'd1, 3'd2, Z);
   endtask

   task automatic flush(input string nm);
      nop(nm, Z);
      nop(nm, Z);
      nop(nm, Z);
   endtask

   initial begin : monitor
      exp_t  e;
      string nm;
      forever begin
         @(negedge clk);
         if (q_exp.size() > 0) begin
            e  = q_exp.pop_front();
            nm = q_name.pop_front();
            compare(nm, w_act, e);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1);
   end

   initial begin : stimulus
      n_cmp   = 0;
      n_err   = 0;
      reset_n = 1'b0;
      drive(5'd1, 5'd1, 3'd0, 3'd0, 5'd1, 3'd0);
      repeat (2) @(posedge clk);
      #1 compare("reset_state", w_act, Z);
      @(negedge clk);
      #2 reset_n = 1'b1;
      drive(5'd0, 5'd0, 3'd7, 3'd7, 5'd0, 3'd0);
      #1 compare("after_release", w_act, Z);
      nop("post_rst", Z);

      // lw $1 ; addu rs=$1
      lw1("s1_lw");
      step("s1_stall", 5'd1, 5'd3, 3'd1, 3'd1, 5'd4, 3'd1, mk(1, 0, 0, 0, 0, 0));
      step("s1_release", 5'd1, 5'd3, 3'd1, 3'd1, 5'd4, 3'd1, Z);
      nop("s1_fwd_e0_w", mk(0, 0, 0, 2, 0, 0));
      flush("s1_flush");

      // addu $1 ; beq rs=$1
      step("s2_addu", 5'd2, 5'd3, 3'd1, 3'd1, 5'd1, 3'd1, Z);
      step("s2_stall", 5'd1, 5'd5, 3'd0, 3'd0, 5'd0, 3'd0, mk(1, 0, 0, 0, 0, 0));
      step("s2_fwd_d0_m", 5'd1, 5'd5, 3'd0, 3'd0, 5'd0, 3'd0, mk(0, 2, 0, 0, 0, 0));
      nop("s2_fwd_e0_w", mk(0, 0, 0, 2, 0, 0));
      nop("s2_flush", Z);
      nop("s2_flush", Z);

      // lui $1 ; beq rt=$1
      step("s3_lui", 5'd0, 5'd0, 3'd7, 3'd7, 5'd1, 3'd0, Z);
      step("s3_fwd_d1_e", 5'd6, 5'd1, 3'd0, 3'd0, 5'd0, 3'd0, mk(0, 0, 1, 0, 0, 0));
      nop("s3_fwd_e1_m", mk(0, 0, 0, 0, 1, 0));
      nop("s3_fwd_m1_w", mk(0, 0, 0, 0, 0, 1));
      nop("s3_flush", Z);
      nop("s3_flush", Z);

      // addu $1 ; sw rt=$1
      step("s4_addu", 5'd2, 5'd3, 3'd1, 3'd1, 5'd1, 3'd1, Z);
      step("s4_sw_nostall", 5'd2, 5'd1, 3'd1, 3'd2, 5'd0, 3'd0, Z);
      nop("s4_fwd_e1_m", mk(0, 0, 0, 0, 1, 0));
      nop("s4_fwd_m1_w", mk(0, 0, 0, 0, 0, 1));
      nop("s4_flush", Z);
      nop("s4_flush", Z);

      // addiu $0 ; beq $0,$0
      step("s5_addiu0", 5'd2, 5'd0, 3'd1, 3'd7, 5'd0, 3'd1, Z);
      step("s5_beq_r0", 5'd0, 5'd0, 3'd0, 3'd0, 5'd0, 3'd0, Z);
      flush("s5_flush");

      // W-stage forward to D, and E-over-M / M-over-W priority
      lw1("s6_lw");
      nop("s6_gap", Z);
      nop("s6_gap", Z);
      step("s6_fwd_d0_w", 5'd1, 5'd0, 3'd0, 3'd7, 5'd0, 3'd0, mk(0, 3, 0, 0, 0, 0));
      nop("s6_flush", Z);
      nop("s6_flush", Z);
      step("s6_lui_a", 5'd0, 5'd0, 3'd7, 3'd7, 5'd1, 3'd0, Z);
      step("s6_lui_b", 5'd0, 5'd0, 3'd7, 3'd7, 5'd1, 3'd0, Z);
      step("s6_prio_d_e", 5'd1, 5'd0, 3'd0, 3'd7, 5'd0, 3'd0, mk(0, 1, 0, 0, 0, 0));
      nop("s6_prio_e_m", mk(0, 0, 0, 1, 0, 0));
      nop("s6_flush", Z);
      nop("s6_flush", Z);

      // tuse 7 never stalls, and a pending producer in M is not forwarded
      lw1("s7_lw");
      step("s7_tuse7", 5'd1, 5'd0, 3'd7, 3'd7, 5'd0, 3'd0, Z);
      nop("s7_m_pending", Z);
      flush("s7_flush");

      // hazard against the M stage, then W-stage forward
      lw1("s8_lw");
      nop("s8_gap", Z);
      step("s8_stall_m", 5'd1, 5'd0, 3'd0, 3'd7, 5'd0, 3'd0, mk(1, 0, 0, 0, 0, 0));
      step("s8_fwd_d0_w", 5'd1, 5'd0, 3'd0, 3'd7, 5'd0, 3'd0, mk(0, 3, 0, 0, 0, 0));
      flush("s8_flush");

      // reset while stalled
      lw1("s9_lw");
      step("s9_stall", 5'd1, 5'd3, 3'd1, 3'd1, 5'd4, 3'd1, mk(1, 0, 0, 0, 0, 0));
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1 compare("rst_async_clear", w_act, Z);
      @(posedge clk);
      #1 drive(5'd0, 5'd0, 3'd7, 3'd7, 5'd0, 3'd0);
      compare("rst_held", w_act, Z);
      @(negedge clk);
      #2 reset_n = 1'b1;
      #1 compare("rst_released", w_act, Z);
      nop("s9_post", Z);
      lw1("s9_lw_again");
      step("s9_stall_again", 5'd1, 5'd3, 3'd1, 3'd1, 5'd4, 3'd1, mk(1, 0, 0, 0, 0, 0));
      step("s9_once_only", 5'd1, 5'd3, 3'd1, 3'd1, 5'd4, 3'd1, Z);
      nop("s9_fwd_e0_w", mk(0, 0, 0, 2, 0, 0));
      flush("s9_flush");

      @(negedge clk);
      #1;
      n_cmp++;
      if (q_exp.size() != 0) begin
         n_err++;
         $display("FAIL queue_drained: got %0d pending, expected 0", q_exp.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
